mem_burst_reader: RTL and testbench

Read-side initiator for the byte-wide image memory of the DCNN IO module. Given a start address and a byte count, it issues one read request at a time to the memory, waits for the memory's done handshake and captures each returned byte. The bytes go into a small first-word-fall-through FIFO, which drains to the convolution front end over a valid/ready stream. It sits between the memory responder and the CNN input pipeline and owns all address sequencing for bulk reads.

---
 rtl/mem_burst_reader.sv | 161 ++++++++++++++++
 tb/tb_mem_burst_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Bulk read initiator: walks a byte address range one request at a time and streams the bytes
// out through a small FWFT FIFO. Optional read timeout abort is enabled by MEM_RD_TIMEOUT_EN.
module mem_burst_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_burst_reader: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, GAP, FLUSH} state_t;
    state_t state;

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, fifo_clr;

    assign push      = mem_rd && mem_done;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_mem[rd_ptr];
    assign mem_addr  = addr;

`ifdef MEM_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;
    assign err      = err_q;
    assign fifo_clr = (state == REQ) && !mem_done && (wait_cnt == TO_LAST);
`else
    assign err      = 1'b0;
    assign fifo_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (RST || fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= length;
                        busy      <= 1'b1;
`ifdef MEM_RD_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        // FIFO is always empty in IDLE, so an empty transfer completes at once.
                        if (length == '0) begin
                            state <= FLUSH;
                            done  <= 1'b1;
                        end else begin
                            state  <= REQ;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_done) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        mem_rd    <= 1'b0;
                        state     <= GAP;
                    end
`ifdef MEM_RD_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        err_q  <= 1'b1;
                        mem_rd <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (remaining == '0) begin
                        state <= FLUSH;
                    end else if (count < DEPTH_C) begin
                        state  <= REQ;
                        mem_rd <= 1'b1;
`ifdef MEM_RD_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                FLUSH: begin
                    // done is held for exactly one cycle; busy drops together with it.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (count == '0) begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader: a memory responder plus address/data queues
// predict every request address and every streamed byte of each transfer.
module tb_mem_burst_reader;
    localparam int AW = 16, DW = 8, LW = 16, DEPTH = 4, TO = 8;

    logic          clk = 1'b0, RST = 1'b1, start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, err, mem_rd, out_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0, out_data;
    logic          mem_done = 1'b0, out_ready = 1'b0;

    always #5 clk = ~clk;

    mem_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .RST(RST), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [15:0] d;
        d = a - 16'h0010;
        return (d[7:0] + 8'hA1) ^ d[15:8];
    endfunction

    // Reference model: queued expected request addresses and output bytes.
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int reads_issued = 0, bytes_popped = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0;
    logic prev_rd = 1'b0, prev_hs = 1'b0;
    logic [15:0] prev_addr = '0;

    // Memory responder: answers after 0..lat_max cycles, injects stray mem_done while idle.
    logic resp_hold = 1'b0;
    int lat_max = 1, lat = 0, wait_c = 0;
    always @(posedge clk) begin
        #1;
        if (mem_rd && !resp_hold) begin
            if (wait_c >= lat) begin
                mem_done  = 1'b1;
                mem_rdata = mem_byte(mem_addr);
                wait_c    = 0;
                lat       = $urandom_range(0, lat_max);
            end else begin
                mem_done = 1'b0;
                wait_c++;
            end
        end else begin
            mem_done  = !resp_hold && ($urandom_range(0, 3) == 0);
            mem_rdata = 8'($urandom);
            wait_c    = 0;
        end
    end

    always @(negedge clk) begin
        if (!RST) begin
            if (prev_hs) chk("gap_after_done", 32'(mem_rd), 32'd0);
            if (mem_rd && prev_rd) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            if (mem_rd && !prev_rd) begin
                reads_issued++;
                chk("rd_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                chk("fifo_room", 32'((reads_issued - bytes_popped) <= DEPTH), 32'd1);
            end
            if (out_valid && out_ready) begin
                bytes_popped++;
                chk("byte_expected", 32'(exp_data.size() > 0), 32'd1);
                if (exp_data.size() > 0) chk("out_data", 32'(out_data), 32'(exp_data.pop_front()));
            end
            if (mem_rd && mem_done) hs_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
        prev_rd   = mem_rd;
        prev_hs   = mem_rd && mem_done;
        prev_addr = mem_addr;
    end

    task automatic start_xfer(input logic [15:0] a, input int l);
        start      = 1'b1;
        start_addr = a;
        length     = 16'(l);
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back(16'(a + 16'(i)));
            exp_data.push_back(mem_byte(16'(a + 16'(i))));
        end
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = 16'($urandom);
        length     = 16'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rd_after_start", 32'(mem_rd), 32'(l != 0));
        chk("done_len0", 32'(done), 32'(l == 0));
    endtask

    // Full transfer; stall>0 holds out_ready low first; exp_cyc>0 checks peak-rate completion.
    task automatic xfer(input logic [15:0] a, input int l, input int ready_pct,
                        input int stall, input int exp_cyc);
        int d0, r0, cyc;
        d0 = done_cnt;
        r0 = reads_issued;
        out_ready = 1'b0;
        start_xfer(a, l);
        cyc = 1;
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; cyc++; end
            chk("stall_reads", 32'(reads_issued - r0), 32'(DEPTH));
            chk("stall_rd_low", 32'(mem_rd), 32'd0);
            chk("stall_no_done", 32'(done_cnt - d0), 32'd0);
        end
        while (done_cnt == d0 && cyc < 600) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if ($urandom_range(0, 7) == 0) begin
                start = 1'b1; start_addr = 16'($urandom); length = 16'($urandom_range(1, 5));
            end else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("reads_total", 32'(reads_issued - r0), 32'(l));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("queues_drained", 32'(exp_addr.size() + exp_data.size()), 32'd0);
        if (exp_cyc > 0) chk("xfer_cycles", 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        RST = 1'b0;
        @(posedge clk); #1;

        // Peak rate: reply in first REQ cycle, consumer always ready.
        lat_max = 0; lat = 0;
        xfer(16'h0010, 3, 100, 0, 2 * 3 + 3);
        lat_max = 2;
        xfer(16'h0100, 6, 100, 30, 0);
        xfer(16'hFFFE, 3, 70, 0, 0);
        xfer(16'h4000, 0, 100, 0, 0);
        xfer(16'h0200, 1, 100, 0, 0);

        // Reset in the middle of a 5-byte transfer, after two reads complete.
        begin
            int h0, n, d0;
            h0 = hs_cnt; n = 0;
            out_ready = 1'b0;
            start_xfer(16'h2000, 5);
            while (hs_cnt - h0 < 2 && n < 100) begin @(posedge clk); #1; n++; end
            chk("rst_mid_reads", 32'(hs_cnt - h0), 32'd2);
            RST = 1'b1;
            @(posedge clk); #1;
            RST = 1'b0;
            chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
            chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
            chk("mid_rst_busy", 32'(busy), 32'd0);
            exp_addr.delete(); exp_data.delete();
            reads_issued = 0; bytes_popped = 0;
            d0 = done_cnt;
            repeat (6) begin @(posedge clk); #1; end
            chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        end
        xfer(16'h2000, 5, 100, 0, 0);

`ifdef MEM_RD_TIMEOUT_EN
        begin
            int e0, d0, n, rdc;
            e0 = err_cnt; d0 = done_cnt; n = 0; rdc = 0;
            resp_hold = 1'b1;
            start_xfer(16'h3000, 3);
            while (err_cnt == e0 && n < 100) begin
                if (mem_rd) rdc++;
                @(posedge clk); #1; n++;
            end
            repeat (4) begin @(posedge clk); #1; end
            chk("to_req_cycles", 32'(rdc), 32'(TO));
            chk("to_err_pulses", 32'(err_cnt - e0), 32'd1);
            chk("to_no_done", 32'(done_cnt - d0), 32'd0);
            chk("to_busy", 32'(busy), 32'd0);
            chk("to_mem_rd", 32'(mem_rd), 32'd0);
            chk("to_out_valid", 32'(out_valid), 32'd0);
            resp_hold = 1'b0;
            exp_addr.delete(); exp_data.delete();
            reads_issued = 0; bytes_popped = 0;
        end
`endif

        // Randomized transfers: address, length, latency and consumer readiness.
        for (int t = 0; t < 10; t++) begin
            lat_max = $urandom_range(0, 3);
            xfer(16'($urandom), $urandom_range(0, 12), (t % 3 == 0) ? 30 : ((t % 3 == 1) ? 70 : 100), 0, 0);
        end

`ifndef MEM_RD_TIMEOUT_EN
        chk("err_never", 32'(err_cnt), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
